uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter. It accepts bytes from the core side into an internal FIFO and serialises them onto the line as 8N1 frames, LSB first, with an optional even-parity bit. Frames go out back-to-back while the FIFO holds data. It is the transmit-side partner of UART_RX on a shared line: loopback benches and board top levels drive UART_RX from its o_TX_Serial.

## Interface
- CLKS_PER_BIT, 217, clocks per bit period (25 MHz / 115200); must be ≥ 2
- FIFO_DEPTH, 8, byte entries; must be a power of two, ≥ 2
- i_Clock  input  1  system clock, rising edge
- i_Rst_L  input  1  reset; one clock, reset asynchronous and active-low
- i_TX_DV  input  1  write strobe; byte accepted on a rising edge when i_TX_DV && o_TX_Ready
- i_TX_Byte  input  8  byte to write
- o_TX_Ready  output  1  FIFO not full
- o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  bytes queued, not counting the frame in flight
- o_TX_Active  output  1  high from the first start-bit clock to the last stop-bit clock
- o_TX_Serial  output  1  line output, idle high
- o_TX_Done  output  1  one-clock pulse on the last clock of each stop bit

## Operation
- Reset values (asynchronous, i_Rst_L low):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Count=0, o_TX_Ready=1.
  - FSM goes to IDLE; FIFO pointers go to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: when the FIFO is non-empty, pop one byte into the shift register. The start bit (0) is driven from the next clock.
- START → DATA: after CLKS_PER_BIT clocks.
- DATA: drive shift[bit_idx] for CLKS_PER_BIT clocks per bit, bit_idx 0..7.
  - After bit 7, go to PARITY if parity is compiled in, else to STOP.
- PARITY: drive ^byte (even parity) for CLKS_PER_BIT clocks.
- STOP: drive 1 for CLKS_PER_BIT clocks; pulse o_TX_Done on the final clock.
  - If the FIFO is non-empty at that clock, pop and go straight to START (no idle gap).
  - Otherwise go to IDLE.
- Counters:
  - Bit-period counter is $clog2(CLKS_PER_BIT) bits wide; counts 0..CLKS_PER_BIT-1 and wraps to 0 on each state/bit advance.
  - bit_idx is 3 bits.
- FIFO rules:
  - A write while full is silently dropped; count and contents are unchanged.
  - Simultaneous write and pop: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- o_TX_Ready is combinational from the registered count (count < FIFO_DEPTH). It reflects the state before the current edge, so a write arriving in the same cycle as a pop from a full FIFO is dropped.
- Reset mid-frame: the line returns to 1 immediately (asynchronously) and the FIFO is flushed. There is no truncated-frame recovery.

## Timing
- Write on edge N: o_FIFO_Count increments after edge N.
- If IDLE and empty, the pop occurs at edge N+1, and o_TX_Serial falls and o_TX_Active rises after edge N+1.
- Frame length is 10 × CLKS_PER_BIT clocks, or 11 × CLKS_PER_BIT with parity.
- Back-to-back frames: the start bit of frame k+1 follows the last stop-bit clock of frame k on the very next clock.
- o_TX_Active stays high across back-to-back frames.
- o_TX_Done is high for exactly one clock per frame.
- All outputs are registered except o_TX_Ready.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is present; frames are 8E1, 11 bit periods.
  - Undefined: the PARITY state and parity logic are absent; frames are 8N1.
- Must match the UART_RX configuration on the same line.

## Structure
- Package uart_pkg holds:
  - the tx FSM state encoding (IDLE..STOP)
  - UART_DATA_BITS = 8
  - a frame-length constant that follows UART_TX_PARITY_EN
- Sub-module uart_sync_fifo: parameterised width/depth, single clock, async active-low reset. Ports: write en/data, read en/data, count, full, empty.
- The FSM and shifter live in uart_tx_buffered.

## Test plan
- Single byte 0x4F, CLKS_PER_BIT=217: the line shows start, then 1,1,1,1,0,0,1,0 LSB first, then stop, each bit 217 clocks (8680 ns). A looped-back UART_RX reports 0x4F. o_TX_Done pulses once.
- Burst of 8 bytes 0x00..0x07 in 8 consecutive clocks:
  - o_FIFO_Count peaks at 7 (the first byte pops immediately).
  - Eight frames are contiguous with no idle gap; o_TX_Active is high throughout; RX receives 0x00..0x07 in order.
- Overflow, FIFO_DEPTH=8, 10 consecutive writes 0xA0..0xA9:
  - Count reaches 8 and o_TX_Ready drops.
  - 0xA9 is dropped (0xA0 popped, 0xA1..0xA8 queued), so 9 bytes are transmitted.
- Write from a full FIFO in the same cycle as a pop: the byte is dropped; count goes from 8 to 7.
- Reset asserted mid-DATA of 0x55: o_TX_Serial=1, o_TX_Active=0, count=0 immediately. After release, a new write of 0x3C transmits cleanly.
- With UART_TX_PARITY_EN: byte 0x07 gives parity bit 1, byte 0x03 gives 0; frames are 2387 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: tx FSM encoding, data width and frame length.
// UART_TX_PARITY_EN selects 8E1 (11-bit frames) instead of 8N1 (10-bit frames).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; one-cycle write-to-visible latency.
// Writes while full and reads while empty are ignored; count is registered.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_fire, rd_fire;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_fire   = wr_en_i && !full_o;
    assign rd_fire   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        if (wr_fire && !rd_fire) begin
            count_d = count_q + 1'b1;
        end else if (!wr_fire && rd_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser (8E1 with UART_TX_PARITY_EN), frames back-to-back.
// First start bit one clock after the write; o_TX_Ready drops when the FIFO is full and extra writes are dropped.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);

    import uart_pkg::*;

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      serial_q, serial_d;
    logic                      active_q, active_d;
    logic                      done_q, done_d;

    logic                      fifo_pop, fifo_full, fifo_empty, bit_end;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_Clock),
        .rst_ni    (i_Rst_L),
        .wr_en_i   (i_TX_DV),
        .wr_data_i (i_TX_Byte),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .count_o   (o_FIFO_Count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign o_TX_Ready  = !fifo_full;
    assign o_TX_Serial = serial_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;
    assign bit_end     = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == TX_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    state_d  = TX_START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    serial_d  = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = TX_PARITY;
                        serial_d = even_parity(shift_q);
`else
                        state_d  = TX_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    state_d  = TX_STOP;
                    serial_d = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                // done is registered, so raise it one clock early to land on the last stop clock
                done_d = (cnt_q == CNT_PRE);
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = TX_START;
                        serial_d = 1'b0;
                    end else begin
                        state_d  = TX_IDLE;
                        active_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = TX_IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised self-checking bench for uart_tx_buffered against a queue/frame-position reference model.
module tb_uart_tx_buffered;

    localparam int CPB   = 10;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN     = 1'b0;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic       i_Clock = 1'b0;
    logic       i_Rst_L = 1'b1;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done;
    logic [3:0] o_FIFO_Count;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Rst_L      (i_Rst_L),
        .i_TX_DV      (i_TX_DV),
        .i_TX_Byte    (i_TX_Byte),
        .o_TX_Ready   (o_TX_Ready),
        .o_FIFO_Count (o_FIFO_Count),
        .o_TX_Active  (o_TX_Active),
        .o_TX_Serial  (o_TX_Serial),
        .o_TX_Done    (o_TX_Done)
    );

    always #5 i_Clock = ~i_Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued bytes plus the clocks remaining in the frame on the line.
    logic [7:0] q[$];
    logic [7:0] cur_byte = 8'h00;
    int         frame_left = 0;
    int         done_seen = 0;
    int         peak = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_serial();
        int pos, bitn;
        if (frame_left == 0) return 1'b1;
        pos  = FRAME_CLKS - frame_left;
        bitn = pos / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return cur_byte[bitn-1];
        if (PAR_EN && bitn == 9) return ^cur_byte;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        frame_left = 0;
    endtask

    // One clock: drive inputs, check ready before the edge, advance model, check outputs after it.
    task automatic tick(input logic dv, input logic [7:0] b);
        int pre;
        pre       = q.size();
        i_TX_DV   = dv;
        i_TX_Byte = b;
        check("ready", o_TX_Ready, pre < DEPTH);
        @(posedge i_Clock);
        if (pre > 0 && frame_left <= 1) begin
            cur_byte   = q.pop_front();
            frame_left = FRAME_CLKS;
        end else if (frame_left > 0) begin
            frame_left--;
        end
        if (dv && pre < DEPTH) q.push_back(b);
        #1;
        i_TX_DV = 1'b0;
        check("serial", o_TX_Serial, exp_serial());
        check("active", o_TX_Active, frame_left > 0);
        check("done",   o_TX_Done,   frame_left == 1);
        check("count",  o_FIFO_Count, q.size());
        done_seen += int'(o_TX_Done);
        if (int'(o_FIFO_Count) > peak) peak = int'(o_FIFO_Count);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 * FRAME_CLKS && (frame_left > 0 || q.size() > 0); n++) tick(1'b0, 8'h00);
        repeat (3) tick(1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] rb;
        #1 i_Rst_L = 1'b0;
        #1;
        check("rst_serial", o_TX_Serial, 1'b1);
        check("rst_active", o_TX_Active, 1'b0);
        check("rst_done",   o_TX_Done,   1'b0);
        check("rst_count",  o_FIFO_Count, 0);
        check("rst_ready",  o_TX_Ready,  1'b1);
        repeat (2) @(posedge i_Clock);
        #1 i_Rst_L = 1'b1;

        done_seen = 0;
        tick(1'b1, 8'h4F);
        drain();
        check("single_done_pulses", done_seen, 1);

        peak = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(i));
        drain();
        check("burst_peak", peak, 7);

        done_seen = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, 8'hA0 + 8'(i));
        check("ovf_count", o_FIFO_Count, 8);
        check("ovf_ready", o_TX_Ready, 1'b0);
        drain();
        check("ovf_frames", done_seen, 9);

        for (int i = 0; i < 9; i++) tick(1'b1, 8'hC0 + 8'(i));
        for (int n = 0; n < 2 * FRAME_CLKS && frame_left != 1; n++) tick(1'b0, 8'h00);
        tick(1'b1, 8'hEE);
        check("full_pop_count", o_FIFO_Count, 7);
        drain();

        tick(1'b1, 8'h55);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        repeat (3 * CPB) tick(1'b0, 8'h00);
        #2 i_Rst_L = 1'b0;
        #1;
        model_reset();
        check("midrst_serial", o_TX_Serial, 1'b1);
        check("midrst_active", o_TX_Active, 1'b0);
        check("midrst_count",  o_FIFO_Count, 0);
        check("midrst_done",   o_TX_Done,   1'b0);
        @(posedge i_Clock);
        #1;
        check("midrst_hold_serial", o_TX_Serial, 1'b1);
        i_Rst_L = 1'b1;
        tick(1'b1, 8'h3C);
        drain();

        tick(1'b1, 8'h07);
        tick(1'b1, 8'h03);
        drain();

        for (int i = 0; i < 300; i++) begin
            rb = 8'($urandom);
            tick($urandom_range(0, 3) == 0, rb);
        end
        drain();
        for (int i = 0; i < 600; i++) begin
            rb = 8'($urandom);
            tick($urandom_range(0, 19) == 0, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
